// File: rtl/wb_snoop_responder_if.sv
// Bundle of snoop-side and core-update signals for one wb_snoop_responder.
// slave  : the responder itself.
// master : whatever drives it (arbiter slice plus core, or a testbench).
// Handshakes:
//   snoop  - the arbiter holds snoop_type_i/snoop_adr_i until it sees a response.
//            It then releases by driving type 00.
//   update - upd_valid_i is held with stable payload until upd_ready_o is high
//            at a rising edge. That edge transfers the update.
interface wb_snoop_responder_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0] snoop_adr_i;
    logic [1:0]    snoop_type_i;
    logic [1:0]    snoop_response_o;
    logic [dw-1:0] snooped_dat_o;
    logic          upd_valid_i;
    logic          upd_ready_o;
    logic [aw-1:0] upd_adr_i;
    logic [dw-1:0] upd_dat_i;
    logic          upd_dirty_i;
    logic          upd_inv_i;
    logic          inv_o;
    logic [aw-1:0] inv_adr_o;
    logic          busy_o;

    modport slave (
        input  snoop_adr_i, snoop_type_i, upd_valid_i, upd_adr_i, upd_dat_i,
               upd_dirty_i, upd_inv_i,
        output snoop_response_o, snooped_dat_o, upd_ready_o, inv_o, inv_adr_o,
               busy_o
    );

    modport master (
        output snoop_adr_i, snoop_type_i, upd_valid_i, upd_adr_i, upd_dat_i,
               upd_dirty_i, upd_inv_i,
        input  snoop_response_o, snooped_dat_o, upd_ready_o, inv_o, inv_adr_o,
               busy_o
    );
endinterface

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder with a direct-mapped, word-granular shadow directory.
//
// Snoop timing:
//   edge N   : a snoop is captured and the FSM enters LOOKUP.
//   edge N+1 : the directory entry is read and hit/data are registered.
//   edge N+2 : the FSM enters RESPOND and the registered response appears.
//              A write hit also clears the entry and pulses inv_o here.
// The responder then holds its response until snoop_type_i returns to 00.
module wb_snoop_responder #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int num_lines = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_snoop_responder_if.slave  bus,
    output logic [1:0]           state_o
);
    localparam int idx_bits = $clog2(num_lines);
    localparam int tw       = aw - idx_bits - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] snp_adr_q, snp_adr_d;
    logic          snp_wr_q, snp_wr_d;
    logic          lk_done_q, lk_done_d;
    logic          hit_q, hit_d;
    logic [dw-1:0] hit_dat_q, hit_dat_d;
    logic [1:0]    resp_q, resp_d;
    logic [dw-1:0] dat_q, dat_d;
    logic          inv_q, inv_d;
    logic [aw-1:0] inv_adr_q, inv_adr_d;

    logic          valid_q [num_lines];
    logic          valid_d [num_lines];
    logic          dirty_q [num_lines];
    logic          dirty_d [num_lines];
    logic [tw-1:0] tag_q   [num_lines];
    logic [tw-1:0] tag_d   [num_lines];
    logic [dw-1:0] data_q  [num_lines];
    logic [dw-1:0] data_d  [num_lines];

    logic [idx_bits-1:0] upd_idx, snp_idx;
    logic [tw-1:0]       upd_tag, snp_tag;
    logic                unused_adr_lsbs;

    // Word-granular split: byte-offset bits [1:0] never take part in matching.
    assign upd_idx = bus.upd_adr_i[idx_bits+1:2];
    assign upd_tag = bus.upd_adr_i[aw-1:idx_bits+2];
    assign snp_idx = snp_adr_q[idx_bits+1:2];
    assign snp_tag = snp_adr_q[aw-1:idx_bits+2];
    assign unused_adr_lsbs = ^bus.upd_adr_i[1:0];

    // Next-state, directory update and registered-output computation.
    always_comb begin
        state_d   = state_q;
        snp_adr_d = snp_adr_q;
        snp_wr_d  = snp_wr_q;
        lk_done_d = lk_done_q;
        hit_d     = hit_q;
        hit_dat_d = hit_dat_q;
        resp_d    = resp_q;
        dat_d     = dat_q;
        inv_d     = 1'b0;
        inv_adr_d = inv_adr_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                // The update lands on the same edge as a snoop capture.
                // A snoop to the same address therefore sees the new entry.
                if (bus.upd_valid_i) begin
                    if (bus.upd_inv_i) begin
                        valid_d[upd_idx] = 1'b0;
                        dirty_d[upd_idx] = 1'b0;
                    end else begin
                        valid_d[upd_idx] = 1'b1;
                        dirty_d[upd_idx] = bus.upd_dirty_i;
                        tag_d[upd_idx]   = upd_tag;
                        data_d[upd_idx]  = bus.upd_dat_i;
                    end
                end
                if (bus.snoop_type_i == 2'b01 || bus.snoop_type_i == 2'b10) begin
                    snp_adr_d = bus.snoop_adr_i;
                    snp_wr_d  = (bus.snoop_type_i == 2'b10);
                    lk_done_d = 1'b0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!lk_done_q) begin
                    hit_d     = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
                    hit_dat_d = data_q[snp_idx];
                    lk_done_d = 1'b1;
                end else begin
                    state_d = RESPOND;
                    resp_d  = hit_q ? 2'b10 : 2'b01;
                    dat_d   = (hit_q && !snp_wr_q) ? hit_dat_q : '0;
                    if (hit_q && snp_wr_q) begin
                        valid_d[snp_idx] = 1'b0;
                        dirty_d[snp_idx] = 1'b0;
                        inv_d            = 1'b1;
                        inv_adr_d        = snp_adr_q;
                    end
                end
            end
            RESPOND: begin
                if (bus.snoop_type_i == 2'b00) begin
                    state_d = IDLE;
                    resp_d  = 2'b00;
                    dat_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                resp_d  = 2'b00;
                dat_d   = '0;
            end
        endcase
    end

    // Control, response and directory registers; reset empties the directory.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            snp_adr_q <= '0;
            snp_wr_q  <= 1'b0;
            lk_done_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_dat_q <= '0;
            resp_q    <= 2'b00;
            dat_q     <= '0;
            inv_q     <= 1'b0;
            inv_adr_q <= '0;
            for (int i = 0; i < num_lines; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            snp_adr_q <= snp_adr_d;
            snp_wr_q  <= snp_wr_d;
            lk_done_q <= lk_done_d;
            hit_q     <= hit_d;
            hit_dat_q <= hit_dat_d;
            resp_q    <= resp_d;
            dat_q     <= dat_d;
            inv_q     <= inv_d;
            inv_adr_q <= inv_adr_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end

    assign bus.snoop_response_o = resp_q;
    assign bus.snooped_dat_o    = dat_q;
    assign bus.inv_o            = inv_q;
    assign bus.inv_adr_o        = inv_adr_q;
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.upd_ready_o      = (state_q == IDLE);
    assign state_o              = state_q;
endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench for wb_snoop_responder.
// A table of update+snoop transactions, then hand-written multi-cycle corner cases.
module tb_wb_snoop_responder;
  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         n_checks = 0;
  int         n_pass   = 0;

  wb_snoop_responder_if #(.dw(32), .aw(32)) bus ();

  wb_snoop_responder #(.dw(32), .aw(32), .num_lines(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus),
    .state_o  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_upd;
    logic        upd_inv;
    logic [31:0] upd_adr;
    logic [31:0] upd_dat;
    logic [1:0]  typ;
    logic [31:0] adr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_dat;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // driver: directory update, waits (bounded) for ready
  task automatic do_upd(input logic [31:0] adr, input logic [31:0] dat,
                        input logic dirty, input logic inv);
    int w = 0;
    bus.upd_valid_i = 1'b1;
    bus.upd_adr_i   = adr;
    bus.upd_dat_i   = dat;
    bus.upd_dirty_i = dirty;
    bus.upd_inv_i   = inv;
    while (!bus.upd_ready_o && w < 20) begin
      tick();
      w++;
    end
    chk("upd_ready_before_accept", bus.upd_ready_o, 1);
    tick();
    bus.upd_valid_i = 1'b0;
    bus.upd_inv_i   = 1'b0;
  endtask

  // driver: one full snoop with cycle-by-cycle checks, then release
  task automatic do_snoop(input string nm, input logic [1:0] typ, input logic [31:0] adr,
                          input logic [1:0] er, input logic [31:0] ed, input logic ei);
    bus.snoop_type_i = typ;
    bus.snoop_adr_i  = adr;
    tick();                                   // edge N
    chk({nm, " busy@N"}, bus.busy_o, 1);
    chk({nm, " resp@N"}, bus.snoop_response_o, 2'b00);
    chk({nm, " ready@N"}, bus.upd_ready_o, 0);
    tick();                                   // edge N+1
    chk({nm, " resp@N+1"}, bus.snoop_response_o, 2'b00);
    tick();                                   // edge N+2
    chk({nm, " resp@N+2"}, bus.snoop_response_o, er);
    chk({nm, " dat@N+2"}, bus.snooped_dat_o, ed);
    chk({nm, " inv@N+2"}, bus.inv_o, ei);
    chk({nm, " state@N+2"}, state, 2'd2);
    if (ei) chk({nm, " inv_adr"}, bus.inv_adr_o, adr);
    bus.snoop_adr_i = adr ^ 32'h40;           // must be ignored while held
    tick();                                   // edge N+3
    chk({nm, " resp_hold"}, bus.snoop_response_o, er);
    chk({nm, " dat_hold"}, bus.snooped_dat_o, ed);
    chk({nm, " inv_end"}, bus.inv_o, 0);
    bus.snoop_type_i = 2'b00;
    tick();                                   // release edge
    chk({nm, " resp_rel"}, bus.snoop_response_o, 2'b00);
    chk({nm, " dat_rel"}, bus.snooped_dat_o, 0);
    chk({nm, " busy_rel"}, bus.busy_o, 0);
  endtask

  initial begin
    // idx = adr[5:2], tag = adr[31:6]
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h100,      2'b01, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h100,      32'hDEADBEEF, 2'b01, 32'h100,      2'b10, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h100,      2'b10, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h140,      2'b01, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h100,      2'b10, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h204,      32'h12345678, 2'b01, 32'h204,      2'b10, 32'h12345678, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b10, 32'h100,      2'b10, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h100,      2'b01, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b01, 32'h204,      2'b10, 32'h12345678, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        2'b10, 32'h300,      2'b01, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h204,      32'h0,        2'b01, 32'h204,      2'b01, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h3C,       32'hA5A5A5A5, 2'b01, 32'h3F,       2'b10, 32'hA5A5A5A5, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFC0, 32'hCAFEF00D, 2'b01, 32'hFFFFFFC0, 2'b10, 32'hCAFEF00D, 1'b0};

    rst_n            = 1'b0;
    bus.snoop_adr_i  = '0;
    bus.snoop_type_i = 2'b00;
    bus.upd_valid_i  = 1'b0;
    bus.upd_adr_i    = '0;
    bus.upd_dat_i    = '0;
    bus.upd_dirty_i  = 1'b0;
    bus.upd_inv_i    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst resp", bus.snoop_response_o, 2'b00);
    chk("rst dat", bus.snooped_dat_o, 0);
    chk("rst inv", bus.inv_o, 0);
    chk("rst inv_adr", bus.inv_adr_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst ready", bus.upd_ready_o, 1);
    chk("rst state", state, 2'd0);

    // table-driven transactions
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_upd) do_upd(vecs[i].upd_adr, vecs[i].upd_dat, 1'b1, vecs[i].upd_inv);
      do_snoop($sformatf("vec%0d", i), vecs[i].typ, vecs[i].adr,
               vecs[i].exp_resp, vecs[i].exp_dat, vecs[i].exp_inv);
    end

    // update and snoop on the same edge: lookup must see the new entry
    bus.upd_valid_i  = 1'b1;
    bus.upd_adr_i    = 32'h480;
    bus.upd_dat_i    = 32'h55;
    bus.upd_dirty_i  = 1'b0;
    bus.upd_inv_i    = 1'b0;
    bus.snoop_type_i = 2'b01;
    bus.snoop_adr_i  = 32'h480;
    tick();
    bus.upd_valid_i = 1'b0;
    tick();
    tick();
    chk("same_edge resp", bus.snoop_response_o, 2'b10);
    chk("same_edge dat", bus.snooped_dat_o, 32'h55);
    bus.snoop_type_i = 2'b00;
    tick();
    chk("same_edge release", bus.busy_o, 0);

    // update held during a snoop: stalled until IDLE, then accepted
    bus.snoop_type_i = 2'b01;
    bus.snoop_adr_i  = 32'h204;
    tick();
    bus.upd_valid_i = 1'b1;
    bus.upd_adr_i   = 32'h208;
    bus.upd_dat_i   = 32'h77;
    chk("stall ready@N", bus.upd_ready_o, 0);
    tick();
    chk("stall ready@N+1", bus.upd_ready_o, 0);
    tick();
    chk("stall resp", bus.snoop_response_o, 2'b01);
    chk("stall ready@N+2", bus.upd_ready_o, 0);
    bus.snoop_type_i = 2'b00;
    tick();
    chk("stall ready_idle", bus.upd_ready_o, 1);
    tick();
    bus.upd_valid_i = 1'b0;
    do_snoop("after_stall", 2'b01, 32'h208, 2'b10, 32'h77, 1'b0);

    // type 11 in IDLE is ignored
    bus.snoop_type_i = 2'b11;
    bus.snoop_adr_i  = 32'h208;
    tick();
    tick();
    chk("type11 busy", bus.busy_o, 0);
    chk("type11 state", state, 2'd0);
    chk("type11 resp", bus.snoop_response_o, 2'b00);
    chk("type11 ready", bus.upd_ready_o, 1);
    bus.snoop_type_i = 2'b00;
    tick();

    // reset while responding
    do_upd(32'h100, 32'h11112222, 1'b1, 1'b0);
    do_snoop("pre_reset_wr", 2'b10, 32'h208, 2'b10, 32'h0, 1'b1);
    bus.snoop_type_i = 2'b01;
    bus.snoop_adr_i  = 32'h100;
    tick();
    tick();
    tick();
    chk("pre_reset resp", bus.snoop_response_o, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_rst resp", bus.snoop_response_o, 2'b00);
    chk("async_rst dat", bus.snooped_dat_o, 0);
    chk("async_rst busy", bus.busy_o, 0);
    chk("async_rst inv_adr", bus.inv_adr_o, 0);
    chk("async_rst ready", bus.upd_ready_o, 1);
    bus.snoop_type_i = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    do_snoop("post_reset", 2'b01, 32'h100, 2'b01, 32'h0, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
